lsu_sequencer: RTL

- Controller that sequences the 8-bit external memory port on behalf of the scheduler's LSU request interface.
- Accepts one request at a time: byte or word, load or store, tagged A/B station.
- Splits word accesses into two little-endian byte cycles and returns load data with its tag as a write-back pulse.
- Applies back-pressure through rq_wait, which the scheduler uses to freeze its front register.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_watchdog.sv | 28 ++
 rtl/lsu_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory-port sequencer: FSM states and request field values.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  localparam logic CMD_LOAD  = 1'b0;
  localparam logic CMD_STORE = 1'b1;
  localparam logic WIDTH_8   = 1'b0;
  localparam logic WIDTH_16  = 1'b1;
  localparam logic TAG_A     = 1'b0;
  localparam logic TAG_B     = 1'b1;

endpackage

// File: rtl/lsu_watchdog.sv
// Per-byte-access wait-state counter; flags an abort once TIMEOUT cycles pass without mem_ready.
module lsu_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WD_W    = 8
) (
  input  logic clk,
  input  logic a_rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_expire_c
);

  logic [WD_W-1:0] r_cnt;

  // Counter is zero whenever a fresh byte access starts, since leaving LO/HI or completing clears it.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_cnt <= '0;
    end else if (!i_active || i_ready || o_expire_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WD_W'(1);
    end
  end

  assign o_expire_c = i_active & ~i_ready & (r_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_sequencer.sv
// Sequences one LSU request at a time onto the 8-bit memory port, splitting words into two bytes.
// Optional wait-state watchdog enabled by defining LSU_WATCHDOG_EN.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WD_W    = 8
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        rq_start,
  input  logic        rq_cmd,
  input  logic        rq_width,
  input  logic        rq_tag,
  input  logic [15:0] rq_addr,
  input  logic [15:0] rq_data,
  output logic        rq_wait,
  output logic [15:0] data_out,
  output logic        data_tag,
  output logic        data_wb,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  output logic        lsu_err
);

  if (TIMEOUT == 0 || TIMEOUT >= (64'd1 << WD_W)) begin : g_bad_cfg
    $error("lsu_sequencer: TIMEOUT must be nonzero and fit in WD_W bits");
  end

  lsu_state_e  r_state;
  logic        r_cmd;
  logic        r_width;
  logic        r_tag;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic [7:0]  r_lo;
  logic        w_abort;

  assign rq_wait = (r_state == ST_LO) | (r_state == ST_HI);

`ifdef LSU_WATCHDOG_EN
  lsu_watchdog #(
    .TIMEOUT (TIMEOUT),
    .WD_W    (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .a_rst      (a_rst),
    .i_active   (rq_wait),
    .i_ready    (mem_ready),
    .o_expire_c (w_abort)
  );
`else
  assign w_abort = 1'b0;
`endif

  // Memory strobes/address are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state  <= ST_IDLE;
      r_cmd    <= CMD_LOAD;
      r_width  <= WIDTH_8;
      r_tag    <= TAG_A;
      r_addr   <= '0;
      r_data   <= '0;
      r_lo     <= '0;
      data_out <= '0;
      data_tag <= TAG_A;
      data_wb  <= 1'b0;
      mem_adr  <= '0;
      mem_dout <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      lsu_err  <= 1'b0;
    end else begin
      data_wb <= 1'b0;
      lsu_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_WB: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          r_state <= ST_IDLE;
          if (rq_start) begin
            r_state  <= ST_LO;
            r_cmd    <= rq_cmd;
            r_width  <= rq_width;
            r_tag    <= rq_tag;
            r_addr   <= rq_addr;
            r_data   <= rq_data;
            mem_adr  <= rq_addr;
            mem_dout <= rq_data[7:0];
            mem_rd   <= (rq_cmd == CMD_LOAD);
            mem_wr   <= (rq_cmd == CMD_STORE);
          end
        end
        ST_LO: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            lsu_err <= 1'b1;
          end else if (mem_ready) begin
            if (r_cmd == CMD_LOAD) begin
              r_lo <= mem_din;
            end
            if (r_width == WIDTH_16) begin
              r_state  <= ST_HI;
              mem_adr  <= r_addr + 16'd1;
              mem_dout <= r_data[15:8];
            end else begin
              mem_rd <= 1'b0;
              mem_wr <= 1'b0;
              if (r_cmd == CMD_LOAD) begin
                r_state  <= ST_WB;
                data_out <= {8'h00, mem_din};
                data_tag <= r_tag;
                data_wb  <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        ST_HI: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            lsu_err <= 1'b1;
          end else if (mem_ready) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (r_cmd == CMD_LOAD) begin
              r_state  <= ST_WB;
              data_out <= {mem_din, r_lo};
              data_tag <= r_tag;
              data_wb  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
